// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity checker: FSM states and parameter defaults.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int FRAME_LEN_DEF  = 8;
    localparam int PARITY_ODD_DEF = 0;
    localparam int ERR_CNT_W_DEF  = 8;

    // Counter wide enough to hold the value frame_len itself.
    function automatic int cnt_width(input int frame_len);
        return (frame_len < 2) ? 1 : $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/parity_accum.sv
// Running XOR of accepted data bits; clear has priority over enable.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic acc
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   acc <= 1'b0;
        else if (clr) acc <= 1'b0;
        else if (en)  acc <= acc ^ din;
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Frame-based serial parity checker: FRAME_LEN data bits then one parity bit,
// with a registered result, one-cycle done pulse and a saturating error counter.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int PARITY_ODD = PARITY_ODD_DEF,
    parameter int ERR_CNT_W  = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 parity_out,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int                   CNT_W    = cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(FRAME_LEN - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
    localparam logic                 ODD      = (PARITY_ODD != 0);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             acc;
    logic             acc_clr;
    logic             acc_en;
    logic             capture;
    logic             exp_parity;
    logic             mismatch;

    assign acc_clr    = (state == ST_IDLE) && start;
    assign acc_en     = (state == ST_DATA) && bit_valid;
    assign capture    = (state == ST_PARITY) && bit_valid;
    assign exp_parity = acc ^ ODD;
    assign mismatch   = bit_in ^ exp_parity;

    parity_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .din   (bit_in),
        .acc   (acc)
    );

    // FSM with registered outputs; done is cleared by default and pulsed on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            parity_out <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_valid) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (bit_valid) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        parity_out <= exp_parity;
                        parity_err <= mismatch;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Clear beats a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (err_clr)
            err_count <= '0;
        else if (capture && mismatch && (err_count != ERR_MAX))
            err_count <= err_count + 1'b1;
    end

endmodule
